// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD frame-buffer scan-out block.
// Used by lcd_fb_scanout and lcd_fb_ram.
package lcd_pkg;

  localparam int LCD_W      = 160;
  localparam int LCD_H      = 144;
  localparam int LCD_PIXELS = LCD_W * LCD_H;

  localparam int H_SYNC_START = 168;
  localparam int H_SYNC_END   = 183;
  localparam int V_SYNC_START = 146;
  localparam int V_SYNC_END   = 147;

  typedef logic [1:0]  shade_t;
  typedef logic [11:0] rgb_t;

  // Index 0 is the lightest shade, index 3 the darkest.
  localparam logic [3:0][11:0] PALETTE = {12'h021, 12'h365, 12'h8B7, 12'hEFD};

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  function automatic rgb_t shade_to_rgb(input shade_t s);
    return PALETTE[s];
  endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the read register resets.
module lcd_fb_ram
  import lcd_pkg::*;
#(
  parameter int DEPTH = LCD_PIXELS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  shade_t        wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output shade_t        rdata_o
);

  shade_t mem_q [DEPTH];
  shade_t rdata_q;

  // Separate processes with non-blocking updates give read-first behaviour
  // when both ports hit the same address in one cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_fb_scanout.sv
// LCD frame buffer with 2-stage scan-out (RAM read, palette lookup) and sync timing.
// Define LCD_FB_DOUBLE_BUFFER_EN for two banks swapped at frame wrap after frame_done.
module lcd_fb_scanout
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 144,
  parameter int H_TOTAL  = 200,
  parameter int V_TOTAL  = 154
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pixel_in,
  input  logic [14:0] lcd_addr,
  input  logic        lcd_write,
  input  logic        frame_done,
  input  logic        pix_ce,
  output logic [11:0] rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last, frame_wrap;

  assign h_last     = (hcnt_q == HW'(H_TOTAL - 1));
  assign v_last     = (vcnt_q == VW'(V_TOTAL - 1));
  assign frame_wrap = pix_ce && h_last && v_last;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  timing_t     tim_now;
  logic [14:0] pix_addr;

  always_comb begin
    tim_now    = '0;
    tim_now.de = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    tim_now.hs = (hcnt_q >= HW'(H_SYNC_START)) && (hcnt_q <= HW'(H_SYNC_END));
    tim_now.vs = (vcnt_q >= VW'(V_SYNC_START)) && (vcnt_q <= VW'(V_SYNC_END));
    // vcnt*160 as vcnt*128 + vcnt*32
    pix_addr   = '0;
    if (tim_now.de)
      pix_addr = 15'({vcnt_q, 7'b0}) + 15'({vcnt_q, 5'b0}) + 15'(hcnt_q);
  end

  logic wr_en;
  assign wr_en = lcd_write && (lcd_addr < 15'(LCD_PIXELS)) && !rst;

`ifdef LCD_FB_DOUBLE_BUFFER_EN
  localparam int DEPTH = 2 * LCD_PIXELS;
  localparam int AW    = $clog2(DEPTH);

  logic wsel_q, wsel_d, pend_q, pend_d;

  // A frame_done landing on the wrap cycle itself still swaps at that wrap.
  always_comb begin
    wsel_d = wsel_q;
    pend_d = pend_q | frame_done;
    if (frame_wrap) begin
      wsel_d = wsel_q ^ (pend_q | frame_done);
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      wsel_q <= wsel_d;
      pend_q <= pend_d;
    end
  end

  logic [AW-1:0] waddr, raddr;
  assign waddr = wsel_q ? AW'(lcd_addr) + AW'(LCD_PIXELS) : AW'(lcd_addr);
  assign raddr = wsel_q ? AW'(pix_addr) : AW'(pix_addr) + AW'(LCD_PIXELS);
`else
  localparam int DEPTH = LCD_PIXELS;
  localparam int AW    = $clog2(DEPTH);

  logic unused_frame_done;
  assign unused_frame_done = frame_done ^ frame_wrap;

  logic [AW-1:0] waddr, raddr;
  assign waddr = AW'(lcd_addr);
  assign raddr = AW'(pix_addr);
`endif

  shade_t rd_shade;

  lcd_fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (pixel_in),
    .re_i    (pix_ce),
    .raddr_i (raddr),
    .rdata_o (rd_shade)
  );

  // Stage 1 timing travels beside the RAM read register; stage 2 beside rgb.
  timing_t [2:1] tim_pipe_q;
  rgb_t          rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_pipe_q <= '0;
      rgb_q      <= '0;
    end else if (pix_ce) begin
      tim_pipe_q <= {tim_pipe_q[1], tim_now};
      rgb_q      <= tim_pipe_q[1].de ? shade_to_rgb(rd_shade) : 12'h000;
    end
  end

  assign rgb_o   = rgb_q;
  assign de_o    = tim_pipe_q[2].de;
  assign hsync_o = tim_pipe_q[2].hs;
  assign vsync_o = tim_pipe_q[2].vs;

endmodule

// File: tb/tb_lcd_fb_scanout.sv
// Self-checking bench for lcd_fb_scanout against a frame-level reference model.
// Honours LCD_FB_DOUBLE_BUFFER_EN the same way as the design.
module tb_lcd_fb_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pixel_in;
  logic [14:0] lcd_addr;
  logic        lcd_write, frame_done, pix_ce;
  logic [11:0] rgb_o;
  logic        de_o, hsync_o, vsync_o;

  always #5 clk = ~clk;

  lcd_fb_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_in   (pixel_in),
    .lcd_addr   (lcd_addr),
    .lcd_write  (lcd_write),
    .frame_done (frame_done),
    .pix_ce     (pix_ce),
    .rgb_o      (rgb_o),
    .de_o       (de_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o)
  );

`ifdef LCD_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int PIX = 23040;

  typedef struct {
    int         rgb;   // -1: pixel never written, colour not predictable
    logic [2:0] sync;  // {de, hs, vs}
  } exp_t;

  int   checks = 0, failures = 0;
  int   mem [2][PIX];
  int   pal [4] = '{'hEFD, 'h8B7, 'h365, 'h021};
  bit   m_wsel, m_pend;
  int   hpos, vpos;
  exp_t q[$];
  exp_t exp_o;

  // What the display should show for raster position (h,v) given the model memory.
  function automatic exp_t scan_val(input int h, input int v);
    exp_t e;
    int   m;
    bit   de;
    de     = (h < 160) && (v < 144);
    e.sync = {de, (h >= 168 && h <= 183), (v >= 146 && v <= 147)};
    e.rgb  = 0;
    if (de) begin
      m     = mem[DB ? int'(!m_wsel) : 0][v * 160 + h];
      e.rgb = (m < 0) ? -1 : pal[m];
    end
    return e;
  endfunction

  task automatic model_reset();
    exp_t z;
    z.rgb = 0; z.sync = 3'b000;
    hpos = 0; vpos = 0; m_wsel = 0; m_pend = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    exp_o = z;
  endtask

  // One clock: drive, let the edge happen, update the model, settle.
  task automatic cycle(input bit pce, input bit wr, input int addr, input int pix, input bit fd);
    int wb;
    pix_ce = pce; lcd_write = wr; lcd_addr = addr[14:0]; pixel_in = pix[1:0]; frame_done = fd;
    @(posedge clk);
    wb = DB ? int'(m_wsel) : 0;
    if (pce) begin
      q.push_back(scan_val(hpos, vpos));
      void'(q.pop_front());
      if (hpos == 199 && vpos == 153) begin
        if (m_pend || fd) m_wsel = DB ? !m_wsel : m_wsel;
        m_pend = 0;
      end else if (fd) m_pend = 1;
      hpos++;
      if (hpos == 200) begin hpos = 0; vpos = (vpos + 1) % 154; end
    end else if (fd) m_pend = 1;
    if (wr && addr < PIX) mem[wb][addr] = pix;
    exp_o = q[0];
    #1;
  endtask

  // Reset asserted between edges with a write that must be dropped.
  task automatic assert_rst();
    rst = 1'b1; lcd_write = 1'b1; lcd_addr = '0; pixel_in = 2'd0; pix_ce = 1'b1; frame_done = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0; lcd_write = 1'b0; pix_ce = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++;
    if ({rgb_o, de_o, hsync_o, vsync_o} !== 15'd0) begin
      failures++; $display("FAIL reset_state got rgb=%h de/hs/vs=%b%b%b want all 0", rgb_o, de_o, hsync_o, vsync_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rgb_o, de_o, hsync_o, vsync_o} !== 15'd0) begin
      failures++; $display("FAIL reset_held got rgb=%h de/hs/vs=%b%b%b want all 0", rgb_o, de_o, hsync_o, vsync_o);
    end
    rst = 1'b0; lcd_write = 1'b0; pix_ce = 1'b0;
    model_reset();
  endtask

  task automatic test_first_pixel();
    cycle(0, 1, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL first_pixel k=%0d got rgb=%h sync=%b want rgb=%h sync=%b", k, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
`ifndef LCD_FB_DOUBLE_BUFFER_EN
      if (k == 1) begin
        checks++;
        if (rgb_o !== 12'h021 || de_o !== 1'b1) begin
          failures++; $display("FAIL first_pixel_latency got rgb=%h de=%b want rgb=021 de=1", rgb_o, de_o);
        end
      end
`endif
    end
  endtask

  task automatic test_oob_and_retention();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, (k == 0) ? PIX : int'($urandom_range(PIX, 32767)), 0, 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL oob_write k=%0d got rgb=%h sync=%b want rgb=%h sync=%b", k, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
    end
    assert_rst();
    checks++;
    if ({rgb_o, de_o, hsync_o, vsync_o} !== 15'd0) begin
      failures++; $display("FAIL oob_reset got rgb=%h de/hs/vs=%b%b%b want all 0", rgb_o, de_o, hsync_o, vsync_o);
    end
    release_rst();
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 0, 0, 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL readback k=%0d got rgb=%h sync=%b want rgb=%h sync=%b", k, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
    end
`ifndef LCD_FB_DOUBLE_BUFFER_EN
    checks++;
    if (rgb_o !== 12'h021) begin
      failures++; $display("FAIL readback_addr0 got rgb=%h want 021", rgb_o);
    end
`endif
  endtask

  task automatic test_free_run();
    int cnt_h = 0, cnt_v = 0, cnt_de = 0;
    for (int i = 0; i < 30800; i++) begin
      cycle(1, 1, (i < PIX) ? i : int'($urandom_range(PIX, 32767)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 999) == 0));
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL free_run i=%0d got rgb=%h sync=%b want rgb=%h sync=%b", i, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
      cnt_h += int'(hsync_o); cnt_v += int'(vsync_o); cnt_de += int'(de_o);
    end
    checks++;
    if (cnt_h != 16 * 154) begin failures++; $display("FAIL hsync_count got %0d want %0d", cnt_h, 16 * 154); end
    checks++;
    if (cnt_v != 2 * 200) begin failures++; $display("FAIL vsync_count got %0d want %0d", cnt_v, 2 * 200); end
    checks++;
    if (cnt_de != PIX) begin failures++; $display("FAIL de_count got %0d want %0d", cnt_de, PIX); end
  endtask

  task automatic test_reset_midline();
    for (int n = 0; n < 400 && hpos != 77; n++) begin
      cycle(1, 1, int'($urandom_range(0, PIX - 1)), int'($urandom_range(0, 3)), 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL pre_midline got rgb=%h sync=%b want rgb=%h sync=%b", rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
    end
    checks++;
    if (hpos != 77) begin failures++; $display("FAIL midline_reach got hpos=%0d want 77", hpos); end
    assert_rst();
    checks++;
    if ({rgb_o, de_o, hsync_o, vsync_o} !== 15'd0) begin
      failures++; $display("FAIL midline_reset got rgb=%h de/hs/vs=%b%b%b want all 0", rgb_o, de_o, hsync_o, vsync_o);
    end
    release_rst();
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 0, 0, 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL post_midline k=%0d got rgb=%h sync=%b want rgb=%h sync=%b", k, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
      if (k < 2) begin
        checks++;
        if (de_o !== (k == 1)) begin
          failures++; $display("FAIL restart_latency k=%0d got de=%b want %0d", k, de_o, (k == 1));
        end
      end
    end
  endtask

  task automatic test_ce_div();
    for (int k = 0; k < 1600; k++) begin
      cycle((k % 4) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, PIX - 1)), int'($urandom_range(0, 3)), 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL ce_div k=%0d got rgb=%h sync=%b want rgb=%h sync=%b", k, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
    end
  endtask

`ifdef LCD_FB_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    int n;
    assert_rst();
    release_rst();
    for (int i = 0; i < PIX; i++) cycle(1, 1, i, 1, 0);
    for (n = 0; n < 40000 && !(vpos == 150 && hpos == 0); n++) cycle(1, 0, 0, 0, 0);
    checks++;
    if (vpos != 150) begin failures++; $display("FAIL db_reach_line150 got vpos=%0d want 150", vpos); end
    cycle(1, 0, 0, 0, 1);
    for (n = 0; n < 2000 && !(vpos == 0 && hpos == 0); n++) cycle(1, 0, 0, 0, 0);
    checks++;
    if (vpos != 0 || hpos != 0) begin failures++; $display("FAIL db_reach_wrap got pos=%0d,%0d want 0,0", hpos, vpos); end
    for (int i = 0; i < 8000; i++) begin
      cycle(1, 1, int'($urandom_range(0, PIX - 1)), 3, 0);
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp_o.sync || (exp_o.rgb >= 0 && rgb_o !== exp_o.rgb[11:0])) begin
        failures++; $display("FAIL db_frame i=%0d got rgb=%h sync=%b want rgb=%h sync=%b", i, rgb_o, {de_o, hsync_o, vsync_o}, exp_o.rgb[11:0], exp_o.sync);
      end
      if (exp_o.sync[2]) begin
        checks++;
        if (rgb_o !== 12'h8B7) begin failures++; $display("FAIL db_shade1 i=%0d got rgb=%h want 8B7", i, rgb_o); end
      end
    end
  endtask
`endif

  initial begin
    foreach (mem[b, a]) mem[b][a] = -1;
    rst = 1'b1; pixel_in = '0; lcd_addr = '0; frame_done = 1'b0; pix_ce = 1'b0;
    lcd_write = 1'b1;
    #1;
    test_reset();
    test_first_pixel();
    test_oob_and_retention();
    test_free_run();
    test_reset_midline();
    test_ce_div();
`ifdef LCD_FB_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
